// File: rtl/parity_frame_rx_pkg.sv
// Shared types and constants for the parity_frame_rx serial receiver.
package parity_frame_rx_pkg;

    localparam int DATA_BITS     = 4;
    localparam int FRAME_SAMPLES = 7;
    localparam int CNT_W         = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    // Contents of the single-entry holding register presented to the consumer.
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 par_err;
        logic                 frame_err;
    } rx_word_t;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Valid/ready consumer bus carrying the received nibble and its error flags.
interface parity_frame_rx_if;
    import parity_frame_rx_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 par_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 valid;
    logic                 ready;

    modport master (output data, par_err, frame_err, overrun, valid, input ready);
    modport slave  (input data, par_err, frame_err, overrun, valid, output ready);

endinterface

// File: rtl/parity_frame_rx_xor4.sv
// Existing 4-bit parity checker: y is the XOR reduction of a.
module xor4 (
    input  logic [3:0] a,
    output logic       y
);

    assign y = ^a;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, 4 data bits LSB first, parity, stop; result is
// held in a single-entry register behind a valid/ready handshake.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic                    rx,
    output logic                    busy,
    parity_frame_rx_if.master       bus
);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 shreg_xor;
    rx_word_t             hold;
    logic                 valid_q;
    logic                 overrun_q;

    logic                 start;
    logic                 shift_en;
    logic                 par_en;
    logic                 capture;
    logic                 accept;

    xor4 u_xor4 (
        .a (shreg),
        .y (shreg_xor)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (sample_en) begin
            unique case (state)
                IDLE:    if (!rx) state_next = DATA;
                DATA:    if (count == CNT_W'(DATA_BITS - 1)) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        start    = sample_en && (state == IDLE) && !rx;
        shift_en = sample_en && (state == DATA);
        par_en   = sample_en && (state == PARITY);
        capture  = sample_en && (state == STOP);
    end

    // shreg holds still through PARITY so the xor4 result is settled at STOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (start) begin
                count <= '0;
            end else if (shift_en) begin
                shreg <= {rx, shreg[DATA_BITS-1:1]};
                count <= count + CNT_W'(1);
            end
            if (par_en) par_bit <= rx;
        end
    end

    assign accept = valid_q && bus.ready;

    // A capture always wins; overrun is raised only when it displaces an
    // unaccepted word, and a simultaneous acceptance leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (capture) begin
            hold.data      <= shreg;
            hold.par_err   <= shreg_xor ^ par_bit ^ ODD_PARITY;
            hold.frame_err <= ~rx;
            valid_q        <= 1'b1;
            if (valid_q && !bus.ready) overrun_q <= 1'b1;
        end else if (accept) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign bus.data      = hold.data;
    assign bus.par_err   = hold.par_err;
    assign bus.frame_err = hold.frame_err;
    assign bus.valid     = valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench: even and odd parity receivers driven in parallel and
// compared every cycle against a sample-queue reference model.
module tb_parity_frame_rx;
    import parity_frame_rx_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic sample_en;
    logic rx;
    logic ready;
    logic busy_e;
    logic busy_o;

    parity_frame_rx_if bus_e ();
    parity_frame_rx_if bus_o ();

    assign bus_e.ready = ready;
    assign bus_o.ready = ready;

    parity_frame_rx #(.ODD_PARITY(1'b0)) dut_even (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .rx        (rx),
        .busy      (busy_e),
        .bus       (bus_e.master)
    );

    parity_frame_rx #(.ODD_PARITY(1'b1)) dut_odd (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .rx        (rx),
        .busy      (busy_o),
        .bus       (bus_o.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: collects the 7 samples of a frame, then decodes them.
    logic       frame_q[$];
    logic       m_valid, m_busy, m_ovr, m_perr_e, m_perr_o, m_ferr;
    logic [3:0] m_data;

    function automatic logic [6:0] make_frame(input logic [3:0] nib, input logic par, input logic stop);
        return {stop, par, nib, 1'b0};
    endfunction

    function automatic logic [8:0] exp_vec(input logic odd);
        return {m_valid, m_busy, m_ovr, (odd ? m_perr_o : m_perr_e), m_ferr, m_data};
    endfunction

    function automatic logic [8:0] dut_vec(input logic odd);
        if (odd) return {bus_o.valid, busy_o, bus_o.overrun, bus_o.par_err, bus_o.frame_err, bus_o.data};
        return {bus_e.valid, busy_e, bus_e.overrun, bus_e.par_err, bus_e.frame_err, bus_e.data};
    endfunction

    task automatic apply_reset();
        reset     = 1'b1;
        rx        = 1'b1;
        sample_en = 1'b0;
        ready     = 1'b0;
        frame_q.delete();
        {m_valid, m_busy, m_ovr, m_perr_e, m_perr_o, m_ferr} = '0;
        m_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive_cycle(input logic r, input logic s, input logic rdy);
        logic [3:0] nib;
        logic       done;
        rx        = r;
        sample_en = s;
        ready     = rdy;
        done      = 1'b0;
        nib       = '0;
        if (s) begin
            if (frame_q.size() != 0 || r == 1'b0) frame_q.push_back(r);
            if (frame_q.size() == FRAME_SAMPLES) done = 1'b1;
        end
        if (done) begin
            for (int i = 0; i < DATA_BITS; i++) nib[i] = frame_q[1 + i];
            m_data   = nib;
            m_perr_e = ^{nib, frame_q[5]};
            m_perr_o = ~m_perr_e;
            m_ferr   = ~frame_q[6];
            if (m_valid && !rdy) m_ovr = 1'b1;
            m_valid  = 1'b1;
            frame_q.delete();
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        m_busy = (frame_q.size() != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (dut_vec(0) !== 9'b0 || dut_vec(1) !== 9'b0) begin
            n_bad++;
            $display("FAIL reset: got even=%b odd=%b need all zero", dut_vec(0), dut_vec(1));
        end
    endtask

    task automatic test_basic();
        logic [6:0] f;
        f = make_frame(4'hB, 1'b1, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) begin
            drive_cycle(f[i], 1'b1, 1'b1);
            n_cmp++;
            if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL basic cyc%0d: got %b/%b need %b/%b", i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
            end
        end
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, bus_o.par_err} !== {1'b1, 4'hB, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_hB: got v=%b d=%h pe=%b fe=%b pe_odd=%b need v=1 d=b pe=0 fe=0 pe_odd=1",
                     bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, bus_o.par_err);
        end
        drive_cycle(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (bus_e.valid !== 1'b0 || bus_o.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_accept: got valid=%b/%b need 0", bus_e.valid, bus_o.valid);
        end
    endtask

    task automatic test_parity_flip();
        logic [6:0] f;
        f = make_frame(4'hB, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, 1'b1);
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, bus_o.par_err} !== {1'b1, 4'hB, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL parity_flip: got v=%b d=%h pe=%b fe=%b pe_odd=%b need v=1 d=b pe=1 fe=0 pe_odd=0",
                     bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, bus_o.par_err);
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_frame_err();
        logic [6:0] f;
        f = make_frame(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, 1'b1);
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, busy_e} !== {1'b1, 4'h0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL frame_err: got v=%b d=%h pe=%b fe=%b busy=%b need v=1 d=0 pe=0 fe=1 busy=0",
                     bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, busy_e);
        end
        f = make_frame(4'h5, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) begin
            drive_cycle(f[i], 1'b1, 1'b1);
            n_cmp++;
            if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL frame_err_recover cyc%0d: got %b/%b need %b/%b", i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
            end
        end
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err} !== {1'b1, 4'h5, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL frame_err_h5: got v=%b d=%h pe=%b fe=%b need v=1 d=5 pe=0 fe=0",
                     bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err);
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        logic [6:0] f;
        f = make_frame(4'h3, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, 1'b0);
        f = make_frame(4'hC, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) begin
            drive_cycle(f[i], 1'b1, 1'b0);
            n_cmp++;
            if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                n_bad++;
                $display("FAIL overrun_hold cyc%0d: got %b/%b need %b/%b", i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
            end
        end
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.overrun} !== {1'b1, 4'hC, 1'b1}) begin
            n_bad++;
            $display("FAIL overrun_set: got v=%b d=%h ovr=%b need v=1 d=c ovr=1", bus_e.valid, bus_e.data, bus_e.overrun);
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({bus_e.valid, bus_e.overrun, bus_e.data} !== {1'b0, 1'b0, 4'hC}) begin
            n_bad++;
            $display("FAIL overrun_clear: got v=%b ovr=%b d=%h need v=0 ovr=0 d=c", bus_e.valid, bus_e.overrun, bus_e.data);
        end
    endtask

    task automatic test_strobe();
        logic [6:0] f;
        f = make_frame(4'h9, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) begin
            drive_cycle(f[i], 1'b1, 1'b0);
            n_cmp++;
            if (busy_e !== (i < FRAME_SAMPLES - 1)) begin
                n_bad++;
                $display("FAIL strobe_busy sample%0d: got %b need %b", i, busy_e, (i < FRAME_SAMPLES - 1));
            end
            if (i == FRAME_SAMPLES - 1) begin
                n_cmp++;
                if ({bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err} !== {1'b1, 4'h9, 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL strobe_h9: got v=%b d=%h pe=%b fe=%b need v=1 d=9 pe=0 fe=0",
                             bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err);
                end
            end
            for (int k = 0; k < 3; k++) begin
                drive_cycle(1'($urandom_range(1, 0)), 1'b0, 1'b0);
                n_cmp++;
                if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                    n_bad++;
                    $display("FAIL strobe_hold s%0d k%0d: got %b/%b need %b/%b", i, k, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
                end
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        logic [6:0] f;
        f = make_frame(4'h6, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, 1'b0);
        f = make_frame(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(f[i], 1'b1, 1'b0);
        apply_reset();
        n_cmp++;
        if (dut_vec(0) !== 9'b0 || dut_vec(1) !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_midframe: got even=%b odd=%b need all zero", dut_vec(0), dut_vec(1));
        end
        f = make_frame(4'hA, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, 1'b1);
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, bus_e.overrun} !== {1'b1, 4'hA, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hA: got v=%b d=%h pe=%b fe=%b ovr=%b need v=1 d=a pe=0 fe=0 ovr=0",
                     bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err, bus_e.overrun);
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] f;
        f = make_frame(4'h7, 1'b1, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, 1'b0);
        f = make_frame(4'h2, 1'b1, 1'b1);
        for (int i = 0; i < FRAME_SAMPLES; i++) drive_cycle(f[i], 1'b1, (i == FRAME_SAMPLES - 1));
        n_cmp++;
        if ({bus_e.valid, bus_e.data, bus_e.overrun} !== {1'b1, 4'h2, 1'b0}) begin
            n_bad++;
            $display("FAIL capture_with_accept: got v=%b d=%h ovr=%b need v=1 d=2 ovr=0", bus_e.valid, bus_e.data, bus_e.overrun);
        end
        drive_cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [6:0] f;
        logic [3:0] nib;
        int         errs;
        errs = 0;
        for (int n = 0; n < 60; n++) begin
            nib = 4'($urandom_range(15, 0));
            f = make_frame(nib, (^nib) ^ ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                drive_cycle(1'b1, 1'b1, ($urandom_range(2, 0) != 0));
                n_cmp++;
                if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                    n_bad++;
                    errs++;
                    if (errs < 10) $display("FAIL random_idle f%0d: got %b/%b need %b/%b", n, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
                end
            end
            for (int i = 0; i < FRAME_SAMPLES; i++) begin
                for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
                    drive_cycle(1'($urandom_range(1, 0)), 1'b0, ($urandom_range(2, 0) != 0));
                    n_cmp++;
                    if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                        n_bad++;
                        errs++;
                        if (errs < 10) $display("FAIL random_gap f%0d s%0d: got %b/%b need %b/%b", n, i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
                    end
                end
                drive_cycle(f[i], 1'b1, ($urandom_range(2, 0) != 0));
                n_cmp++;
                if (dut_vec(0) !== exp_vec(0) || dut_vec(1) !== exp_vec(1)) begin
                    n_bad++;
                    errs++;
                    if (errs < 10) $display("FAIL random_sample f%0d s%0d: got %b/%b need %b/%b", n, i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_flip();
        test_frame_err();
        test_overrun();
        test_strobe();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
